// File: rtl/nyan_sequencer_if.sv
// Song ROM bus between the note sequencer (master) and the ROM (slave).
// The address is registered by the master; data follows one cycle later.
interface nyan_sequencer_if #(
    parameter int ADDR_W = 6
) ();
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;

    modport master (output rom_addr, input  rom_data);
    modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/nyan_sequencer.sv
// Note sequencer: walks the song ROM, times each note in tempo ticks, drives
// pitch/gate to the tone generator and exports beat/loop for animation sync.
module nyan_sequencer #(
    parameter int TICK_DIV   = 200000,
    parameter int GAP_CYCLES = 20000,
    parameter int ADDR_W     = 6,
    parameter int SONG_LEN   = 64,
    parameter int LOOP_START = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             restart,
    nyan_sequencer_if.master rom,
    output logic [4:0]       pitch,
    output logic             gate,
    output logic             note_strobe,
    output logic             beat,
    output logic [7:0]       loop_count
);
    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW:0]       GAP_START = (TW+1)'(TICK_DIV - GAP_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
    localparam logic [ADDR_W-1:0] LOOP_ADDR = ADDR_W'(LOOP_START);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [TW-1:0]     tick_cnt;
    logic [2:0]        remaining;
    logic              gate_q, strobe_q, beat_q;
    logic              wrap, note_end, in_gap;

    assign wrap     = (state == PLAY) && (tick_cnt == TICK_LAST);
    assign note_end = wrap && (remaining == 3'd0);
    assign in_gap   = (state == PLAY) && (remaining == 3'd0) && ({1'b0, tick_cnt} >= GAP_START);

    always_comb begin
        state_d = state;
        if (restart) begin
            state_d = FETCH;
        end else if (enable) begin
            case (state)
                IDLE:    state_d = FETCH;
                FETCH:   state_d = LOAD;
                LOAD:    state_d = PLAY;
                PLAY:    if (note_end) state_d = FETCH;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Pulses are cleared on every edge, so a pause never replays a strobe or beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            tick_cnt   <= '0;
            remaining  <= '0;
            pitch      <= '0;
            gate_q     <= 1'b0;
            strobe_q   <= 1'b0;
            beat_q     <= 1'b0;
            loop_count <= '0;
        end else if (restart) begin
            addr_q    <= '0;
            tick_cnt  <= '0;
            remaining <= '0;
            pitch     <= '0;
            gate_q    <= 1'b0;
            strobe_q  <= 1'b0;
            beat_q    <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            beat_q   <= 1'b0;
            if (enable) begin
                case (state)
                    LOAD: begin
                        pitch     <= rom.rom_data[7:3];
                        remaining <= rom.rom_data[2:0];
                        tick_cnt  <= '0;
                        gate_q    <= (rom.rom_data[7:3] != 5'd0);
                        strobe_q  <= 1'b1;
                    end
                    PLAY: begin
                        if (wrap) begin
                            tick_cnt <= '0;
                            beat_q   <= 1'b1;
                            if (remaining != 3'd0) begin
                                remaining <= remaining - 3'd1;
                            end else begin
                                gate_q <= 1'b0;
                                if (addr_q == LAST_ADDR) begin
                                    addr_q     <= LOOP_ADDR;
                                    loop_count <= loop_count + 8'd1;
                                end else begin
                                    addr_q <= addr_q + ADDR_W'(1);
                                end
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rom.rom_addr = addr_q;
    assign gate         = gate_q && enable && !in_gap;
    assign note_strobe  = strobe_q && enable;
    assign beat         = beat_q && enable;
endmodule

// File: tb/tb_nyan_sequencer.sv
// Bench for nyan_sequencer: directed song-timing checks plus randomized
// pause/restart traffic compared every cycle against a note-level model.
module tb_nyan_sequencer;
    localparam int TD  = 8;
    localparam int GAP = 2;
    localparam int AW  = 3;
    localparam int SL  = 4;
    localparam int LS  = 1;
    localparam int M_IDLE = 0, M_FETCH = 1, M_LOAD = 2, M_PLAY = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       restart = 1'b0;
    logic [4:0] pitch;
    logic       gate, note_strobe, beat;
    logic [7:0] loop_count;

    nyan_sequencer_if #(.ADDR_W(AW)) rif ();

    nyan_sequencer #(
        .TICK_DIV(TD), .GAP_CYCLES(GAP), .ADDR_W(AW), .SONG_LEN(SL), .LOOP_START(LS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart), .rom(rif),
        .pitch(pitch), .gate(gate), .note_strobe(note_strobe), .beat(beat),
        .loop_count(loop_count)
    );

    logic [7:0] rom_mem [8] = '{8'h29, 8'h00, 8'hFA, 8'h08, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    always @(posedge clk) rif.rom_data <= rom_mem[rif.rom_addr];

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit mon_on = 0;
    bit rec_on = 0;
    int n_strobes = 0;
    int hi_cnt = 0;
    int st_cyc[$], st_addr[$], st_loop[$], st_hi[$];

    // Note-level reference: time is counted as PLAY cycles elapsed in the note.
    int m_phase = M_IDLE, m_addr = 0, m_elapsed = 0, m_len = 0, m_pitch = 0, m_loops = 0;
    bit m_strobe = 0, m_beat = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        logic [7:0] w;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_phase = M_IDLE; m_addr = 0; m_elapsed = 0; m_len = 0;
            m_pitch = 0; m_loops = 0; m_strobe = 0; m_beat = 0;
        end else begin
            m_strobe = 0;
            m_beat   = 0;
            if (restart) begin
                m_phase = M_FETCH; m_addr = 0; m_elapsed = 0; m_len = 0; m_pitch = 0;
            end else if (enable) begin
                case (m_phase)
                    M_IDLE:  m_phase = M_FETCH;
                    M_FETCH: m_phase = M_LOAD;
                    M_LOAD: begin
                        w = rom_mem[m_addr];
                        m_pitch   = int'(w[7:3]);
                        m_len     = (int'(w[2:0]) + 1) * TD;
                        m_elapsed = 0;
                        m_strobe  = 1;
                        m_phase   = M_PLAY;
                    end
                    default: begin
                        m_elapsed++;
                        if (m_elapsed % TD == 0) m_beat = 1;
                        if (m_elapsed == m_len) begin
                            m_phase = M_FETCH;
                            if (m_addr == SL - 1) begin
                                m_addr = LS;
                                m_loops = (m_loops + 1) % 256;
                            end else begin
                                m_addr++;
                            end
                        end
                    end
                endcase
            end
        end
    end

    function automatic int exp_gate();
        return int'(enable && m_phase == M_PLAY && m_pitch != 0 && m_elapsed < m_len - GAP);
    endfunction

    initial forever begin
        @(negedge clk);
        if (mon_on) begin
            check_eq("rom_addr", int'(rif.rom_addr), m_addr);
            check_eq("pitch", int'(pitch), m_pitch);
            check_eq("gate", int'(gate), exp_gate());
            check_eq("note_strobe", int'(note_strobe), int'(m_strobe && enable));
            check_eq("beat", int'(beat), int'(m_beat && enable));
            check_eq("loop_count", int'(loop_count), m_loops);
        end
        if (note_strobe) n_strobes++;
        if (rec_on) begin
            if (note_strobe) begin
                st_cyc.push_back(cyc);
                st_addr.push_back(int'(rif.rom_addr));
                st_loop.push_back(int'(loop_count));
                st_hi.push_back(hi_cnt);
                hi_cnt = int'(gate);
            end else if (gate) begin
                hi_cnt++;
            end
        end
    end

    task automatic wait_strobe(input int addr, input int limit, output int t);
        int k;
        for (k = 0; k < limit; k++) begin
            tick();
            if (note_strobe && int'(rif.rom_addr) == addr) break;
        end
        check_eq($sformatf("wait_strobe_addr%0d", addr), int'(k < limit), 1);
        t = cyc;
    endtask

    initial begin
        int exp_addr [12] = '{0, 1, 2, 3, 1, 2, 3, 1, 2, 3, 1, 2};
        int t0, t1, s0, saved, k, d;
        logic [7:0] w;

        #1 rst_n = 1'b0;
        mon_on = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (10) begin
            tick();
            check_eq("idle_gate", int'(gate), 0);
            check_eq("idle_pitch", int'(pitch), 0);
            check_eq("idle_addr", int'(rif.rom_addr), 0);
        end

        rec_on = 1;
        enable = 1'b1;
        tick(); check_eq("strobe_early1", int'(note_strobe), 0);
        tick(); check_eq("strobe_early2", int'(note_strobe), 0);
        tick();
        check_eq("first_strobe", int'(note_strobe), 1);
        check_eq("first_pitch", int'(pitch), 5);
        check_eq("first_gate", int'(gate), 1);

        for (k = 0; k < 400 && st_cyc.size() < 12; k++) tick();
        rec_on = 0;
        check_eq("strobe_count", st_cyc.size(), 12);
        if (st_cyc.size() >= 12) begin
            for (int i = 0; i < 12; i++) begin
                check_eq($sformatf("order_%0d", i), st_addr[i], exp_addr[i]);
                if (i > 0) begin
                    w = rom_mem[exp_addr[i-1]];
                    d = int'(w[2:0]);
                    check_eq($sformatf("spacing_%0d", i), st_cyc[i] - st_cyc[i-1], (d + 1) * TD + 2);
                    check_eq($sformatf("gate_high_%0d", i), st_hi[i],
                             (w[7:3] != 5'd0) ? (d + 1) * TD - GAP : 0);
                end
            end
            check_eq("loops_before_jump", st_loop[3], 0);
            check_eq("loops_after_1", st_loop[4], 1);
            check_eq("loops_after_2", st_loop[7], 2);
            check_eq("loops_after_3", st_loop[10], 3);
        end

        wait_strobe(2, 100, t0);
        s0 = n_strobes;
        repeat (5) tick();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("pause_gate", int'(gate), 0);
            check_eq("pause_strobe", int'(note_strobe), 0);
            tick();
        end
        enable = 1'b1;
        #1 check_eq("resume_gate", int'(gate), 1);
        wait_strobe(3, 100, t1);
        check_eq("pause_stretch", t1 - t0, 26 + 5);
        check_eq("pause_no_restrobe", n_strobes - s0, 1);

        repeat (3) tick();
        saved = int'(loop_count);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_eq("restart_addr", int'(rif.rom_addr), 0);
        check_eq("restart_gate", int'(gate), 0);
        check_eq("restart_pitch", int'(pitch), 0);
        check_eq("restart_loops", int'(loop_count), saved);
        tick(); check_eq("restart_strobe_early", int'(note_strobe), 0);
        tick();
        check_eq("restart_strobe", int'(note_strobe), 1);
        check_eq("restart_strobe_pitch", int'(pitch), 5);

        for (k = 0; k < 300; k++) begin
            if (m_addr == 3 && m_phase == M_PLAY && m_elapsed == m_len - 1) break;
            tick();
        end
        check_eq("found_note_end", int'(k < 300), 1);
        saved = int'(loop_count);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_eq("restart_wins_addr", int'(rif.rom_addr), 0);
        check_eq("restart_wins_loops", int'(loop_count), saved);
        check_eq("restart_wins_gate", int'(gate), 0);
        tick();
        tick();
        check_eq("restart_wins_strobe", int'(note_strobe), 1);
        check_eq("restart_wins_pitch", int'(pitch), 5);

        repeat (3000) begin
            enable  = ($urandom_range(0, 9) != 0);
            restart = ($urandom_range(0, 199) == 0);
            tick();
        end
        enable  = 1'b1;
        restart = 1'b0;

        for (k = 0; k < 300; k++) begin
            tick();
            if (m_phase == M_PLAY && m_pitch != 0 && m_elapsed < m_len - GAP - 1) break;
        end
        check_eq("found_sounding_note", int'(k < 300), 1);
        #1 check_eq("pre_reset_gate", int'(gate), 1);
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_gate", int'(gate), 0);
        check_eq("async_reset_pitch", int'(pitch), 0);
        check_eq("async_reset_addr", int'(rif.rom_addr), 0);
        check_eq("async_reset_loops", int'(loop_count), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick(); check_eq("post_reset_strobe1", int'(note_strobe), 0);
        tick(); check_eq("post_reset_strobe2", int'(note_strobe), 0);
        tick();
        check_eq("post_reset_strobe", int'(note_strobe), 1);
        check_eq("post_reset_pitch", int'(pitch), 5);
        check_eq("post_reset_addr", int'(rif.rom_addr), 0);
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/nyan_sequencer.md
Name: nyan_sequencer

Overview:
Note sequencer for the music path. It steps through a song ROM with one cycle of read latency and times each note in tempo ticks. It drives pitch and gate to the PWM tone generator and loops the song body forever. It also exports a beat tick and a loop counter so the graphics path can sync its animation to the music.

Parameters:
TICK_DIV, 200000, clock cycles per tempo tick (one 1/16 note); must be >= 2
GAP_CYCLES, 20000, cycles at the end of each note's final tick during which gate is low; must be < TICK_DIV
ADDR_W, 6, ROM address width
SONG_LEN, 64, number of ROM entries played; 2 <= SONG_LEN <= 2^ADDR_W
LOOP_START, 16, address the song jumps to after SONG_LEN-1; must be < SONG_LEN

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = run, 0 = pause (everything freezes)
restart  input  1  single-cycle pulse: restart the song from address 0
rom_addr  output  ADDR_W  registered song ROM address
rom_data  input  8  ROM word, valid the cycle after rom_addr changes; [7:3] pitch (0 = rest), [2:0] duration-1 in ticks
pitch  output  5  current pitch index to the tone generator
gate  output  1  tone on
note_strobe  output  1  one-cycle pulse when a new note is loaded
beat  output  1  one-cycle pulse on each tick wrap
loop_count  output  8  count of completed loops, wraps modulo 256

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; rom_addr, pitch, remaining, tick_cnt, loop_count = 0.
  - gate, note_strobe, beat = 0.
- States: IDLE, FETCH, LOAD, PLAY.
- All state, counters and outputs change only on clock edges where enable=1, except for restart and the forced-low gate/strobe/beat described below.
- IDLE: when enable=1, go to FETCH (rom_addr is already 0).
- FETCH: one cycle; rom_addr holds steady while the ROM registers it; go to LOAD.
- LOAD: rom_data is valid. At the edge:
  - pitch <= rom_data[7:3]; remaining <= rom_data[2:0]; tick_cnt <= 0.
  - gate <= (rom_data[7:3] != 0).
  - note_strobe = 1 for the first PLAY cycle only.
  - go to PLAY.
- PLAY:
  - tick_cnt counts 0..TICK_DIV-1; beat = 1 for the cycle after tick_cnt wraps to 0.
  - On a wrap with remaining != 0: remaining decrements.
  - On a wrap with remaining == 0:
    - rom_addr <= (rom_addr == SONG_LEN-1) ? LOOP_START : rom_addr+1.
    - On that jump back, loop_count increments.
    - Go to FETCH.
  - Articulation: while remaining == 0 and tick_cnt >= TICK_DIV-GAP_CYCLES, gate = 0.
  - A rest keeps gate = 0 for the whole note.
- Timing:
  - A note with duration field d occupies (d+1)*TICK_DIV PLAY cycles, plus 2 overhead cycles (FETCH, LOAD).
  - Gate is high for the first (d+1)*TICK_DIV - GAP_CYCLES PLAY cycles.
- Pause (enable = 0):
  - state, tick_cnt, remaining, rom_addr and loop_count hold.
  - The gate output is forced 0 combinationally; note_strobe and beat are 0.
  - On resume, gate returns to its held value (gap rule still applied) with no re-strobe.
- Restart:
  - A synchronous restart overrides everything, whatever the value of enable.
  - Next cycle: state = FETCH, rom_addr = 0, remaining = 0, tick_cnt = 0, pitch = 0, gate = 0; loop_count unchanged.
  - restart in IDLE also goes to FETCH.
  - If restart and a note-end wrap coincide, restart wins.
- Reset during a note silences the output immediately and returns to IDLE; there are no partial notes after reset.

Test Plan:
Bench config for all scenarios: TICK_DIV=8, GAP_CYCLES=2, SONG_LEN=4, LOOP_START=1. ROM contents: [0]=0x29 (pitch 5, d=1), [1]=0x00 (rest, d=0), [2]=0xFA (pitch 31, d=2), [3]=0x08 (pitch 1, d=0).

1. Reset, hold enable=0 for 10 cycles -> all outputs 0, state IDLE. Raise enable -> note_strobe 3 cycles later with pitch=5, gate=1.
2. Address 0 timing:
   - gate high for 14 cycles, then low for 2.
   - beat pulses 8 cycles apart.
   - rom_addr=1 on the FETCH cycle.
   - next strobe 18 cycles after the first.
3. Run 3 loops:
   - address order 0,1,2,3,1,2,3,1,2,3,1.
   - rest keeps gate=0 for 8 cycles.
   - loop_count reaches 1, 2, 3 at each 3->1 jump.
   - strobe-to-strobe spacings 18,10,26,10,...
4. Drop enable for 5 cycles mid-note at address 2 -> gate=0 while paused; note ends exactly 5 cycles later than the unpaused reference; no extra strobe.
5. Assert restart while at address 3, and again in the same cycle as a note-end wrap -> next cycle rom_addr=0, gate=0, state FETCH; strobe with pitch=5 two cycles later; loop_count unchanged.
6. Drop rst_n asynchronously mid-note (between edges) -> gate and pitch go to 0 before the next edge; after release with enable=1 the sequence restarts at address 0.
